// File: rtl/ldpc_job_scheduler.sv
// ldpc_job_scheduler: round-robin arbiter and job sequencer for the shared ldpc core
module ldpc_job_scheduler #(
  parameter int TIMEOUT = 'h400,
  parameter int ITER_W = 8,
  parameter int SUM_LEN = 32
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [1:0]          req_i,
  input  logic [1:0]          req_mode_i,
  input  logic [2*ITER_W-1:0] req_max_iter_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          job_done_o,
  output logic [1:0]          job_status_o,
  output logic [ITER_W-1:0]   job_iter_o,
  output logic                busy_o,
  output logic                core_start_o,
  output logic                core_abort_o,
  output logic                core_mode_o,
  output logic [ITER_W-1:0]   core_max_iter_o,
  input  logic                core_busy_i,
  input  logic                core_done_i,
  input  logic                core_syndrome_ok_i,
  input  logic [ITER_W-1:0]   core_iter_i,
  output logic [SUM_LEN-1:0]  jobs_ok_o,
  output logic [SUM_LEN-1:0]  jobs_err_o
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, RUN, RELEASE} state_t;
  state_t state;
  logic win, ptr, pick, active, ok;
  logic [CW-1:0] cnt;
  logic [ITER_W-1:0] mi;
  always_comb begin
    pick = (req_i == 2'b11) ? ptr : req_i[1];
    mi = pick ? req_max_iter_i[2*ITER_W-1:ITER_W] : req_max_iter_i[ITER_W-1:0];
    active = (state == WAIT_BUSY) || (state == RUN);
    ok = !core_mode_o || core_syndrome_ok_i;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      win <= 1'b0;
      ptr <= 1'b0;
      cnt <= '0;
      gnt_o <= '0;
      job_done_o <= '0;
      job_status_o <= '0;
      job_iter_o <= '0;
      busy_o <= 1'b0;
      core_start_o <= 1'b0;
      core_abort_o <= 1'b0;
      core_mode_o <= 1'b0;
      core_max_iter_o <= '0;
      jobs_ok_o <= '0;
      jobs_err_o <= '0;
    end else begin
      core_start_o <= 1'b0;
      core_abort_o <= 1'b0;
      job_done_o <= '0;
      if (state == IDLE && |req_i) begin
        win <= pick;
        gnt_o <= pick ? 2'b10 : 2'b01;
        core_start_o <= 1'b1;
        core_mode_o <= req_mode_i[pick];
        core_max_iter_o <= (mi == '0) ? ITER_W'(1) : mi;
        cnt <= '0;
        busy_o <= 1'b1;
        state <= WAIT_BUSY;
      end else if (active && (core_done_i || cnt == LIM)) begin
        job_done_o <= win ? 2'b10 : 2'b01;
        core_abort_o <= !core_done_i;
        job_status_o <= !core_done_i ? 2'b10 : (ok ? 2'b00 : 2'b01);
        job_iter_o <= core_done_i ? core_iter_i : '0;
        if (core_done_i && ok) begin
          if (!(&jobs_ok_o)) jobs_ok_o <= jobs_ok_o + SUM_LEN'(1);
        end else if (!(&jobs_err_o)) jobs_err_o <= jobs_err_o + SUM_LEN'(1);
        state <= RELEASE;
      end else if (active) begin
        cnt <= cnt + CW'(1);
        if (state == WAIT_BUSY && core_busy_i) state <= RUN;
      end else if (state == RELEASE && !req_i[win]) begin
        gnt_o <= '0;
        ptr <= !win;
        busy_o <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/ldpc_job_scheduler.md
Name: ldpc_job_scheduler

Overview:
Arbitrates the single ldpcEncDec encode/decode core between two requesters: requester 0 is the Wishbone register front-end, requester 1 is the serial pin front-end. It grants one requester at a time, sequences the core through start, run and completion, and enforces a cycle timeout. It returns per-job status and iteration count, and keeps saturating job statistics. Sits between both front-ends and the core inside the user project.

Parameters:
TIMEOUT, 'h 00400, cycles from core_start_o to forced abort (must be >= 2)
ITER_W, 8, width of iteration fields
SUM_LEN, 32, width of statistics counters

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous reset, active-high
req_i  in  2  level request per requester; held until job_done_o seen
req_mode_i  in  2  per requester: 0 = encode, 1 = decode
req_max_iter_i  in  2*ITER_W  per requester max iterations; [ITER_W-1:0] belongs to requester 0
gnt_o  out  2  one-hot grant
job_done_o  out  2  one-cycle completion pulse to the granted requester
job_status_o  out  2  00 ok, 01 decode fail, 10 timeout; held until next job completes
job_iter_o  out  ITER_W  core_iter_i captured at completion
busy_o  out  1  high whenever state != IDLE
core_start_o  out  1  one-cycle start pulse
core_abort_o  out  1  one-cycle abort pulse on timeout
core_mode_o  out  1  latched mode of the current job
core_max_iter_o  out  ITER_W  latched max iterations (0 is mapped to 1)
core_busy_i  in  1  core is processing
core_done_i  in  1  one-cycle completion pulse from the core
core_syndrome_ok_i  in  1  syndrome zero; valid with core_done_i
core_iter_i  in  ITER_W  iterations used; valid with core_done_i
jobs_ok_o  out  SUM_LEN  count of ok jobs, saturating
jobs_err_o  out  SUM_LEN  count of fail and timeout jobs, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 0 (requester 0 favoured first), timeout counter 0, counters 0.
- States: IDLE, WAIT_BUSY, RUN, RELEASE. All outputs are registered.
- IDLE, any req_i set: pick the winner round-robin, favouring the requester that did not win last. At the next edge:
  - gnt_o = winner and core_start_o = 1 for that one cycle.
  - Latch core_mode_o and core_max_iter_o; timeout counter = 0.
  - Go to WAIT_BUSY.
  - Request-to-grant latency is 1 cycle.
- WAIT_BUSY: core_busy_i = 1 -> RUN. core_done_i = 1 in the same cycle (or earlier) counts as completion directly.
- RUN: on core_done_i -> complete.
  - Status: encode jobs are always ok. Decode jobs are ok if core_syndrome_ok_i is set, otherwise fail.
- Timeout: the counter increments every cycle in WAIT_BUSY and RUN.
  - When it reaches TIMEOUT-1 with no core_done_i that cycle, complete with status 10 and pulse core_abort_o with job_done_o.
  - core_done_i in that same cycle wins: the job completes normally, no abort.
- Completion, next edge:
  - job_done_o[winner] = 1 for exactly one cycle.
  - job_status_o and job_iter_o updated; job_iter_o = 0 on timeout.
  - The matching counter increments, saturating at all-ones.
  - Go to RELEASE.
- RELEASE: gnt_o stays held until req_i[winner] = 0.
  - Next edge: gnt_o = 0, pointer = the other requester, go to IDLE.
  - Minimum gap between two grants: 1 IDLE cycle.
- A granted requester dropping req_i before completion does not abort the job; the job runs to completion and the done pulse is still emitted.
- A requester without the grant may change req_mode_i and req_max_iter_i freely. Fields are sampled only at the grant edge.
- core_done_i in IDLE or RELEASE is ignored.
- Reset mid-job: the next edge returns everything to reset values, with no abort pulse. The core shares the same reset.
- gnt_o is never multi-hot. core_start_o and core_abort_o never assert in the same cycle.

Test Plan:
- Single decode job: req_i=01, mode 1, max_iter 10. Core busy 2 cycles after start, done after 5 cycles with syndrome_ok=1, iter=3. Expect gnt 1 cycle after req, one start pulse, job_done_o=01, status 00, job_iter_o=3, jobs_ok_o=1.
- Contention: req_i=11 from reset. Expect requester 0 granted first, then requester 1 after req_i[0] drops. The next simultaneous request grants requester 0 again (alternation).
- Decode fail: syndrome_ok=0 with done, iter=10. Expect status 01, jobs_err_o=1. An encode job with syndrome_ok=0 instead gives status 00.
- Timeout: TIMEOUT=16, core never asserts done. Expect job_done_o and core_abort_o in the same cycle, 16 cycles after the start pulse; status 10, job_iter_o=0.
- Boundaries:
  - max_iter=0 gives core_max_iter_o=1.
  - core_done_i on the timeout-limit cycle gives a normal completion with no abort.
  - core_done_i in WAIT_BUSY completes the job.
  - req drop mid-RUN still yields the done pulse.
- Reset during RUN: wb_rst_i high for 1 cycle. Expect all outputs 0 and IDLE next cycle, counters cleared, no job_done_o.
